// File: rtl/xdma_pkg.sv
// Shared types for the XDMA inter-cluster cfg frame path.
//   FrameLenWidth        : width of the frame-length / frame-index header field
//   xdma_cfg_frame_hdr_t : cfg frame header, LSB first (is_first, dma_type, dma_id, flen)
//   xdma_cfg_err_e       : error codes reported by the reassembler
//   xdma_cfg_ctx_state_e : reassembly context state
package xdma_pkg;

    localparam int unsigned FrameLenWidth = 4;
    localparam int unsigned CfgIdWidth    = 4;

    typedef struct packed {
        logic [FrameLenWidth-1:0] flen;
        logic [CfgIdWidth-1:0]    dma_id;
        logic                     dma_type;
        logic                     is_first;
    } xdma_cfg_frame_hdr_t;

    typedef enum logic [1:0] {
        XdmaCfgErrNone   = 2'd0,
        XdmaCfgErrOrphan = 2'd1,
        XdmaCfgErrDup    = 2'd2,
        XdmaCfgErrBadLen = 2'd3
    } xdma_cfg_err_e;

    typedef enum logic [1:0] {
        CtxFree = 2'd0,
        CtxFill = 2'd1,
        CtxDone = 2'd2
    } xdma_cfg_ctx_state_e;

endpackage

// File: rtl/xdma_cfg_ctx.sv
// One reassembly context: state, header fields and payload slots of one message.
//   clk_i, rst_i  : clock, synchronous active-high reset (state only)
//   alloc_i       : store a first frame into slot 0 (context must be FREE)
//   append_i      : store a continuation frame into slot flen_i (context must be FILL)
//   free_i        : release a DONE context and clear its slots
//   type_i, id_i, flen_i, payload_i : decoded fields of the incoming frame
//   state_o, id_o, type_o, total_o, next_o, payload_o : context contents
//   id_match_o    : context is occupied (FILL or DONE) and holds id_i
module xdma_cfg_ctx
    import xdma_pkg::*;
#(
    parameter int unsigned IdW   = 4,
    parameter int unsigned LenW  = 4,
    parameter int unsigned Slots = 4,
    parameter int unsigned SlotW = 502
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alloc_i,
    input  logic                   append_i,
    input  logic                   free_i,
    input  logic                   type_i,
    input  logic [IdW-1:0]         id_i,
    input  logic [LenW-1:0]        flen_i,
    input  logic [SlotW-1:0]       payload_i,
    output xdma_cfg_ctx_state_e    state_o,
    output logic [IdW-1:0]         id_o,
    output logic                   type_o,
    output logic [LenW-1:0]        total_o,
    output logic [LenW-1:0]        next_o,
    output logic [Slots*SlotW-1:0] payload_o,
    output logic                   id_match_o
);

    xdma_cfg_ctx_state_e    state_q;
    logic [IdW-1:0]         id_q;
    logic                   type_q;
    logic [LenW-1:0]        total_q;
    logic [LenW-1:0]        next_q;
    logic [Slots*SlotW-1:0] slots_q;

    // Only the state is reset; the data fields are rewritten on every
    // allocation (all unused slots zeroed), so nothing stale can leak out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CtxFree;
        end else begin
            if (free_i) begin
                state_q <= CtxFree;
                slots_q <= '0;
            end
            if (alloc_i) begin
                id_q    <= id_i;
                type_q  <= type_i;
                total_q <= flen_i;
                next_q  <= LenW'(1);
                slots_q <= (Slots*SlotW)'(payload_i);
                state_q <= (flen_i == LenW'(1)) ? CtxDone : CtxFill;
            end
            if (append_i) begin
                for (int k = 1; k < Slots; k++) begin
                    if (flen_i == LenW'(k)) slots_q[k*SlotW +: SlotW] <= payload_i;
                end
                next_q <= next_q + LenW'(1);
                if (next_q + LenW'(1) == total_q) state_q <= CtxDone;
            end
        end
    end

    assign state_o    = state_q;
    assign id_o       = id_q;
    assign type_o     = type_q;
    assign total_o    = total_q;
    assign next_o     = next_q;
    assign payload_o  = slots_q;
    assign id_match_o = (state_q != CtxFree) && (id_q == id_i);

endmodule

// File: rtl/xdma_cfg_reassembler.sv
// Reassembles multi-frame XDMA cfg messages from remote clusters into one
// descriptor per transfer, tracking up to NrCtx interleaved dma_ids.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i : incoming cfg frames
//   desc_valid_o/desc_ready_i     : completed descriptor handshake
//   desc_id_o, desc_type_o, desc_len_o : header of the completed message
//   desc_reader_addr_o, desc_writer_addr_o : addresses from the first frame
//   desc_payload_o                : slot k = payload of frame k, unused slots 0
//   err_valid_o, err_code_o, err_id_o : one-cycle error report
module xdma_cfg_reassembler #(
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned FrameLenWidth = xdma_pkg::FrameLenWidth,
    parameter int unsigned MaxFrames     = 4,
    parameter int unsigned NrCtx         = 2,
    localparam int unsigned HdrWidth     = 2 + IdWidth + FrameLenWidth,
    localparam int unsigned PayloadWidth = DataWidth - HdrWidth
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [DataWidth-1:0]            in_data_i,
    output logic                            desc_valid_o,
    input  logic                            desc_ready_i,
    output logic [IdWidth-1:0]              desc_id_o,
    output logic                            desc_type_o,
    output logic [FrameLenWidth-1:0]        desc_len_o,
    output logic [AddrWidth-1:0]            desc_reader_addr_o,
    output logic [AddrWidth-1:0]            desc_writer_addr_o,
    output logic [MaxFrames*PayloadWidth-1:0] desc_payload_o,
    output logic                            err_valid_o,
    output logic [1:0]                      err_code_o,
    output logic [IdWidth-1:0]              err_id_o
);

    localparam int unsigned CtxIdxW = (NrCtx > 1) ? $clog2(NrCtx) : 1;

    logic                     is_first, frm_type;
    logic [IdWidth-1:0]       frm_id;
    logic [FrameLenWidth-1:0] frm_flen;
    logic [PayloadWidth-1:0]  frm_payload;

    assign is_first    = in_data_i[0];
    assign frm_type    = in_data_i[1];
    assign frm_id      = in_data_i[2 +: IdWidth];
    assign frm_flen    = in_data_i[2+IdWidth +: FrameLenWidth];
    assign frm_payload = in_data_i[DataWidth-1:HdrWidth];

    xdma_pkg::xdma_cfg_ctx_state_e      ctx_state   [NrCtx];
    logic [IdWidth-1:0]                 ctx_id      [NrCtx];
    logic                               ctx_type    [NrCtx];
    logic [FrameLenWidth-1:0]           ctx_total   [NrCtx];
    logic [FrameLenWidth-1:0]           ctx_next    [NrCtx];
    logic [MaxFrames*PayloadWidth-1:0]  ctx_payload [NrCtx];
    logic [NrCtx-1:0] ctx_match, ctx_alloc, ctx_append, ctx_free;

    logic                     any_free, any_done, dup, any_fill_match, flen_ok, in_hs;
    logic [CtxIdxW-1:0]       alloc_idx, done_idx, out_idx, out_idx_q;
    logic [FrameLenWidth-1:0] match_next;
    logic                     lock_q;
    xdma_pkg::xdma_cfg_err_e  err_d, err_code_q;
    logic                     err_valid_q;
    logic [IdWidth-1:0]       err_id_q;

    // Lowest-index priority encoders; iterating downward lets index 0 win.
    always_comb begin
        any_free       = 1'b0;
        any_done       = 1'b0;
        alloc_idx      = '0;
        done_idx       = '0;
        dup            = 1'b0;
        any_fill_match = 1'b0;
        match_next     = '0;
        for (int i = NrCtx - 1; i >= 0; i--) begin
            if (ctx_state[i] == xdma_pkg::CtxFree) begin
                any_free  = 1'b1;
                alloc_idx = CtxIdxW'(i);
            end
            if (ctx_state[i] == xdma_pkg::CtxDone) begin
                any_done = 1'b1;
                done_idx = CtxIdxW'(i);
            end
            if (ctx_match[i]) dup = 1'b1;
            if (ctx_match[i] && ctx_state[i] == xdma_pkg::CtxFill) begin
                any_fill_match = 1'b1;
                match_next     = ctx_next[i];
            end
        end
    end

    assign flen_ok = (frm_flen != '0) && (frm_flen <= FrameLenWidth'(MaxFrames));

    // Only a first frame that would actually allocate is stalled when every
    // context is busy; duplicate and bad-length first frames are dropped with
    // an error, so they never need a free context and are always taken.
    assign in_ready_o = !(in_valid_i && is_first && !any_free && !dup && flen_ok);
    assign in_hs      = in_valid_i && in_ready_o;

    // Once a descriptor is shown and not taken, the selection is frozen so a
    // lower-index context finishing later cannot swap the outputs under it.
    assign desc_valid_o = any_done;
    assign out_idx      = lock_q ? out_idx_q : done_idx;

    always_comb begin
        err_d = xdma_pkg::XdmaCfgErrNone;
        if (in_hs) begin
            if (is_first) begin
                if (dup)           err_d = xdma_pkg::XdmaCfgErrDup;
                else if (!flen_ok) err_d = xdma_pkg::XdmaCfgErrBadLen;
            end else begin
                if (!any_fill_match)            err_d = xdma_pkg::XdmaCfgErrOrphan;
                else if (frm_flen != match_next) err_d = xdma_pkg::XdmaCfgErrBadLen;
            end
        end
    end

    for (genvar g = 0; g < NrCtx; g++) begin : g_ctx
        assign ctx_alloc[g]  = in_hs && is_first && !dup && flen_ok && (alloc_idx == CtxIdxW'(g));
        assign ctx_append[g] = in_hs && !is_first && ctx_match[g]
                               && (ctx_state[g] == xdma_pkg::CtxFill) && (frm_flen == ctx_next[g]);
        assign ctx_free[g]   = desc_valid_o && desc_ready_i && (out_idx == CtxIdxW'(g));

        xdma_cfg_ctx #(
            .IdW   (IdWidth),
            .LenW  (FrameLenWidth),
            .Slots (MaxFrames),
            .SlotW (PayloadWidth)
        ) u_ctx (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .alloc_i    (ctx_alloc[g]),
            .append_i   (ctx_append[g]),
            .free_i     (ctx_free[g]),
            .type_i     (frm_type),
            .id_i       (frm_id),
            .flen_i     (frm_flen),
            .payload_i  (frm_payload),
            .state_o    (ctx_state[g]),
            .id_o       (ctx_id[g]),
            .type_o     (ctx_type[g]),
            .total_o    (ctx_total[g]),
            .next_o     (ctx_next[g]),
            .payload_o  (ctx_payload[g]),
            .id_match_o (ctx_match[g])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_valid_q <= 1'b0;
            err_code_q  <= xdma_pkg::XdmaCfgErrNone;
            err_id_q    <= '0;
            lock_q      <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            err_valid_q <= (err_d != xdma_pkg::XdmaCfgErrNone);
            err_code_q  <= err_d;
            err_id_q    <= (err_d != xdma_pkg::XdmaCfgErrNone) ? frm_id : '0;
            lock_q      <= desc_valid_o && !desc_ready_i;
            out_idx_q   <= out_idx;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_code_o  = err_code_q;
    assign err_id_o    = err_id_q;

    always_comb begin
        desc_id_o          = '0;
        desc_type_o        = 1'b0;
        desc_len_o         = '0;
        desc_reader_addr_o = '0;
        desc_writer_addr_o = '0;
        desc_payload_o     = '0;
        if (any_done) begin
            desc_id_o          = ctx_id[out_idx];
            desc_type_o        = ctx_type[out_idx];
            desc_len_o         = ctx_total[out_idx];
            desc_reader_addr_o = ctx_payload[out_idx][AddrWidth-1:0];
            desc_writer_addr_o = ctx_payload[out_idx][2*AddrWidth-1:AddrWidth];
            desc_payload_o     = ctx_payload[out_idx];
        end
    end

endmodule

// File: tb/tb_xdma_cfg_reassembler.sv
// Directed bench for xdma_cfg_reassembler with default parameters.
module tb_xdma_cfg_reassembler;
    import xdma_pkg::*;

    localparam int DW  = 512;
    localparam int AW  = 48;
    localparam int IW  = 4;
    localparam int FW  = 4;
    localparam int MF  = 4;
    localparam int NC  = 2;
    localparam int PW  = DW - 2 - IW - FW;
    localparam int UPW = PW - 2 * AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            desc_valid;
    logic            desc_ready;
    logic [IW-1:0]   desc_id;
    logic            desc_type;
    logic [FW-1:0]   desc_len;
    logic [AW-1:0]   desc_rd;
    logic [AW-1:0]   desc_wr;
    logic [MF*PW-1:0] desc_payload;
    logic            err_valid;
    logic [1:0]      err_code;
    logic [IW-1:0]   err_id;

    xdma_cfg_reassembler #(
        .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW),
        .FrameLenWidth(FW), .MaxFrames(MF), .NrCtx(NC)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_data_i          (in_data),
        .desc_valid_o       (desc_valid),
        .desc_ready_i       (desc_ready),
        .desc_id_o          (desc_id),
        .desc_type_o        (desc_type),
        .desc_len_o         (desc_len),
        .desc_reader_addr_o (desc_rd),
        .desc_writer_addr_o (desc_wr),
        .desc_payload_o     (desc_payload),
        .err_valid_o        (err_valid),
        .err_code_o         (err_code),
        .err_id_o           (err_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] frm(input logic first, input logic typ,
                                          input logic [IW-1:0] id, input logic [FW-1:0] flen,
                                          input logic [PW-1:0] pl);
        xdma_cfg_frame_hdr_t h;
        h.is_first = first;
        h.dma_type = typ;
        h.dma_id   = id;
        h.flen     = flen;
        return {pl, h};
    endfunction

    function automatic logic [PW-1:0] fpl(input logic [AW-1:0] rd, input logic [AW-1:0] wr,
                                          input logic [63:0] tag);
        return {UPW'(tag), wr, rd};
    endfunction

    function automatic logic [PW-1:0] cpl(input logic [63:0] tag);
        return PW'(tag);
    endfunction

    function automatic logic [PW-1:0] slot(input int k);
        return desc_payload[k*PW +: PW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] f);
        in_valid = 1'b1;
        in_data  = f;
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic take();
        desc_ready = 1'b1;
        step();
        desc_ready = 1'b0;
    endtask

    logic [PW-1:0] p10, p11, p12, p20, p21, p40, p41, p50, p51, p60;
    logic [PW-1:0] p80, p81, p82, pa0, pc0, pc1, pc2, pd0, p30;

    initial begin
        p30 = fpl(48'h1000, 48'h2000, 64'h33);
        p10 = fpl(48'hA1, 48'hB1, 64'h10); p11 = cpl(64'h11); p12 = cpl(64'h12);
        p20 = fpl(48'hA2, 48'hB2, 64'h20); p21 = cpl(64'h21);
        p40 = fpl(48'hA4, 48'hB4, 64'h40); p41 = cpl(64'h41);
        p50 = fpl(48'hA5, 48'hB5, 64'h50); p51 = cpl(64'h51);
        p60 = fpl(48'hA6, 48'hB6, 64'h60);
        p80 = fpl(48'hA8, 48'hB8, 64'h80); p81 = cpl(64'h81); p82 = cpl(64'h82);
        pa0 = fpl(48'hAA, 48'hBA, 64'hA0);
        pc0 = fpl(48'hAC, 48'hBC, 64'hC0); pc1 = cpl(64'hC1); pc2 = cpl(64'hC2);
        pd0 = fpl(48'hAD, 48'hBD, 64'hD0);

        rst = 1'b1; in_valid = 1'b0; in_data = '0; desc_ready = 1'b0;
        step(); step();
        chk("rst_desc_valid", desc_valid, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_desc_id", desc_id, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        // single-frame message
        send(frm(1, 1, 3, 1, p30));
        chk("single_valid", desc_valid, 1);
        chk("single_id", desc_id, 3);
        chk("single_type", desc_type, 1);
        chk("single_len", desc_len, 1);
        chk("single_rd", desc_rd, 48'h1000);
        chk("single_wr", desc_wr, 48'h2000);
        chk("single_s0", slot(0), p30);
        chk("single_s1", slot(1), 0);
        chk("single_s2", slot(2), 0);
        chk("single_s3", slot(3), 0);
        take();
        chk("single_freed", desc_valid, 0);

        // interleaved messages; id 2 finishes first and is held under backpressure
        send(frm(1, 0, 1, 3, p10));
        send(frm(1, 1, 2, 2, p20));
        send(frm(0, 0, 1, 1, p11));
        send(frm(0, 1, 2, 1, p21));
        chk("il_valid", desc_valid, 1);
        chk("il_id2", desc_id, 2);
        chk("il_len2", desc_len, 2);
        chk("il_id2_s0", slot(0), p20);
        chk("il_id2_s1", slot(1), p21);
        chk("il_id2_s2", slot(2), 0);
        send(frm(0, 0, 1, 2, p12));
        chk("il_hold_id2", desc_id, 2);
        take();
        chk("il_next_valid", desc_valid, 1);
        chk("il_id1", desc_id, 1);
        chk("il_len1", desc_len, 3);
        chk("il_rd1", desc_rd, 48'hA1);
        chk("il_id1_s0", slot(0), p10);
        chk("il_id1_s1", slot(1), p11);
        chk("il_id1_s2", slot(2), p12);
        chk("il_id1_s3", slot(3), 0);
        take();
        chk("il_empty", desc_valid, 0);

        // all contexts busy: a new first frame stalls until one is freed
        send(frm(1, 0, 4, 2, p40));
        send(frm(1, 0, 5, 2, p50));
        in_valid = 1'b1; in_data = frm(1, 0, 6, 1, p60);
        #1;
        chk("full_stall_fill", in_ready, 0);
        in_valid = 1'b0; in_data = '0;
        step();
        send(frm(0, 0, 4, 1, p41));
        chk("full_id4_done", desc_id, 4);
        in_valid = 1'b1; in_data = frm(1, 0, 6, 1, p60); desc_ready = 1'b1;
        #1;
        chk("full_stall_done", in_ready, 0);
        step();
        desc_ready = 1'b0;
        chk("full_ready_after_free", in_ready, 1);
        step();
        in_valid = 1'b0; in_data = '0;
        chk("full_id6_valid", desc_valid, 1);
        chk("full_id6", desc_id, 6);
        take();
        send(frm(0, 0, 5, 1, p51));
        chk("full_id5", desc_id, 5);
        chk("full_id5_s1", slot(1), p51);
        take();

        // error reporting
        send(frm(0, 0, 7, 1, cpl(64'h70)));
        chk("orphan_valid", err_valid, 1);
        chk("orphan_code", err_code, 1);
        chk("orphan_id", err_id, 7);
        step();
        chk("orphan_pulse_end", err_valid, 0);
        send(frm(1, 0, 8, 3, p80));
        chk("open8_no_err", err_valid, 0);
        send(frm(1, 0, 8, 2, fpl(48'hEE, 48'hEE, 64'hEE)));
        chk("dup_code", err_code, 2);
        chk("dup_id", err_id, 8);
        send(frm(0, 0, 8, 2, p82));
        chk("badidx_code", err_code, 3);
        chk("badidx_id", err_id, 8);
        send(frm(1, 0, 9, 5, p10));
        chk("badlen5_code", err_code, 3);
        chk("badlen5_id", err_id, 9);
        send(frm(1, 0, 9, 0, p10));
        chk("badlen0_code", err_code, 3);
        chk("badlen_no_desc", desc_valid, 0);
        send(frm(0, 0, 8, 1, p81));
        chk("cont8_no_err", err_valid, 0);
        send(frm(0, 0, 8, 2, p82));
        chk("id8_valid", desc_valid, 1);
        chk("id8_len", desc_len, 3);
        chk("id8_s0", slot(0), p80);
        chk("id8_s1", slot(1), p81);
        chk("id8_s2", slot(2), p82);
        take();

        // backpressure: outputs held for 5 cycles
        send(frm(1, 1, 10, 1, pa0));
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", desc_valid, 1);
            chk("bp_id", desc_id, 10);
            chk("bp_s0", slot(0), pa0);
            step();
        end
        take();
        chk("bp_freed", desc_valid, 0);

        // reset mid-message drops everything
        send(frm(1, 0, 12, 3, pc0));
        send(frm(0, 0, 12, 1, pc1));
        send(frm(1, 0, 13, 1, pd0));
        chk("pre_rst_valid", desc_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_rst_desc", desc_valid, 0);
        chk("post_rst_err", err_valid, 0);
        chk("post_rst_ready", in_ready, 1);
        send(frm(0, 0, 12, 2, pc2));
        chk("post_rst_orphan", err_code, 1);
        chk("post_rst_orphan_id", err_id, 12);
        chk("post_rst_no_desc", desc_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
